// File: rtl/tdc_pkg.sv
// Shared constants, types and helpers for the delay-line TDC decoder.
package tdc_pkg;

    // Width of the saturating event counters (err_cnt, saturation run length).
    localparam int TDC_CNT_W     = 8;
    // Widest delay line the helpers below are sized for.
    localparam int TDC_MAX_STAGE = 64;

    // Last decoded sample saturation state, held until the next decoded sample.
    typedef struct packed {
        logic hi;
        logic lo;
    } tdc_sat_t;

    // Signed code width for a line of nstage taps: codes span -nstage/2 .. nstage/2-1.
    function automatic int tdc_out_w(input int nstage);
        return $clog2(nstage) + 1;
    endfunction

    // True when the (zero-extended) word has the shape 0..01..1, all-zeros and
    // all-ones included. Adding one to a run of low ones carries past the run,
    // so any surviving common bit means a one sits above a zero.
    function automatic logic is_therm(input logic [TDC_MAX_STAGE-1:0] word);
        return ((word & (word + 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/tdc_dline_decoder_if.sv
// Sampler-side and loop-filter-side signals of the TDC decoder.
//
// Handshake: sample_en qualifies therm_in for exactly the edge it is high on;
// there is no backpressure, the decoder accepts every qualified sample.
// out_valid is a one-cycle pulse marking the edge on which out changed;
// the consumer must take it on that cycle. clear has priority over sample_en.
interface tdc_dline_decoder_if
    import tdc_pkg::*;
#(
    parameter int NSTAGE = 16
);
    localparam int OUT_W = tdc_out_w(NSTAGE);

    logic [NSTAGE-1:0]       therm_in;
    logic                    sample_en;
    logic                    clear;
    logic signed [OUT_W-1:0] out;
    logic                    out_valid;
    logic                    sat_hi;
    logic                    sat_lo;
    logic                    sat_flag;
    logic [TDC_CNT_W-1:0]    err_cnt;

    // Sampler / test driver side.
    modport master (
        output therm_in, sample_en, clear,
        input  out, out_valid, sat_hi, sat_lo, sat_flag, err_cnt
    );

    // Decoder side.
    modport slave (
        input  therm_in, sample_en, clear,
        output out, out_valid, sat_hi, sat_lo, sat_flag, err_cnt
    );

endinterface

// File: rtl/tdc_therm2bin.sv
// Combinational thermometer-to-signed-code converter with optional bubble filter.
module tdc_therm2bin
    import tdc_pkg::*;
#(
    parameter int  NSTAGE = 16,
    parameter int  BUBBLE = 1,
    localparam int OUT_W  = tdc_out_w(NSTAGE)
) (
    input  logic [NSTAGE-1:0]       therm,
    output logic signed [OUT_W-1:0] code,
    output logic                    all0,
    output logic                    all1,
    output logic                    bubble
);

    localparam logic [OUT_W-1:0] HALF  = OUT_W'(NSTAGE / 2);
    localparam logic [OUT_W-1:0] MAX_C = OUT_W'(NSTAGE / 2 - 1);

    // Index 0 is the virtual tap below bit 0 (always 1), index NSTAGE+1 the
    // virtual tap above the top bit (always 0), so edge bits filter sensibly.
    logic [NSTAGE+1:0] padded;
    logic [NSTAGE-1:0] corr;
    logic [OUT_W-1:0]  count;

    assign padded = {1'b0, therm, 1'b1};

    // 3-tap majority filter removes isolated single-bit bubbles.
    always_comb begin
        corr = therm;
        if (BUBBLE != 0) begin
            for (int i = 0; i < NSTAGE; i++) begin
                corr[i] = (padded[i] & padded[i+1]) |
                          (padded[i] & padded[i+2]) |
                          (padded[i+1] & padded[i+2]);
            end
        end
    end

    // Ones-count of the corrected word; NSTAGE always fits in OUT_W unsigned bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            count = count + OUT_W'(corr[i]);
        end
    end

    assign all0 = ~|corr;
    assign all1 = &corr;

    // Only the all-ones count overflows the signed range, so clamp just that case.
    assign code = all1 ? $signed(MAX_C) : $signed(count - HALF);

    // Shape check always looks at the raw captured word.
    assign bubble = ~is_therm(TDC_MAX_STAGE'(therm));

endmodule

// File: rtl/tdc_dline_decoder.sv
// Delay-line TDC back-end: capture, decode, saturation tracking, averaging.
module tdc_dline_decoder
    import tdc_pkg::*;
#(
    parameter int NSTAGE    = 16,
    parameter int AVG_LOG2  = 0,
    parameter int BUBBLE    = 1,
    parameter int SAT_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    tdc_dline_decoder_if.slave   bus
);

    localparam int OUT_W = tdc_out_w(NSTAGE);
    localparam int ACC_W = OUT_W + AVG_LOG2;
    // Keep a 1-bit counter when not averaging; it then stays at 0 forever.
    localparam int WIN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [WIN_W-1:0]     WIN_MAX   = WIN_W'((1 << AVG_LOG2) - 1);
    localparam logic [TDC_CNT_W-1:0] SAT_LIM_C = TDC_CNT_W'(SAT_LIMIT);
    localparam logic [TDC_CNT_W-1:0] CNT_MAX   = '1;

    // Stage 1 capture.
    logic [NSTAGE-1:0]       therm_q, therm_d;
    logic                    v1_q, v1_d;

    // Stage 2 results and running state.
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    tdc_sat_t                sat_q, sat_d;
    logic                    sat_flag_q, sat_flag_d;
    logic [TDC_CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [TDC_CNT_W-1:0]    sat_cnt_q, sat_cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [WIN_W-1:0]        win_q, win_d;

    // Decoder outputs for the captured word.
    logic signed [OUT_W-1:0] code;
    logic                    all0;
    logic                    all1;
    logic                    bubble;

    logic signed [ACC_W-1:0] code_ext;
    logic signed [ACC_W-1:0] acc_sum;

    tdc_therm2bin #(
        .NSTAGE (NSTAGE),
        .BUBBLE (BUBBLE)
    ) u_therm2bin (
        .therm  (therm_q),
        .code   (code),
        .all0   (all0),
        .all1   (all1),
        .bubble (bubble)
    );

    // Next-state logic for capture, decode bookkeeping and the averaging window.
    always_comb begin
        therm_d     = therm_q;
        v1_d        = 1'b0;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sat_d       = sat_q;
        sat_flag_d  = sat_flag_q;
        err_cnt_d   = err_cnt_q;
        sat_cnt_d   = sat_cnt_q;
        acc_d       = acc_q;
        win_d       = win_q;

        code_ext = ACC_W'(code);
        acc_sum  = acc_q + code_ext;

        // A sample arriving together with clear is dropped.
        if (bus.sample_en && !bus.clear) begin
            therm_d = bus.therm_in;
            v1_d    = 1'b1;
        end

        if (bus.clear) begin
            // Flush the in-flight sample and the partial window; results are held.
            acc_d = '0;
            win_d = '0;
        end else if (v1_q) begin
            sat_d.hi = all1;
            sat_d.lo = all0;

            if (bubble && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + TDC_CNT_W'(1);
            end

            if (all0 || all1) begin
                if (sat_cnt_q != CNT_MAX) begin
                    sat_cnt_d = sat_cnt_q + TDC_CNT_W'(1);
                end
            end else begin
                sat_cnt_d = '0;
            end
            sat_flag_d = (sat_cnt_d >= SAT_LIM_C);

            // Window closes on its last sample; the arithmetic shift floors the mean.
            if (win_q == WIN_MAX) begin
                out_d       = OUT_W'(acc_sum >>> AVG_LOG2);
                out_valid_d = 1'b1;
                acc_d       = '0;
                win_d       = '0;
            end else begin
                acc_d = acc_sum;
                win_d = win_q + WIN_W'(1);
            end
        end
    end

    // Pipeline and state registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            therm_q     <= '0;
            v1_q        <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= '0;
            sat_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
            sat_cnt_q   <= '0;
            acc_q       <= '0;
            win_q       <= '0;
        end else begin
            therm_q     <= therm_d;
            v1_q        <= v1_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            sat_flag_q  <= sat_flag_d;
            err_cnt_q   <= err_cnt_d;
            sat_cnt_q   <= sat_cnt_d;
            acc_q       <= acc_d;
            win_q       <= win_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat_hi    = sat_q.hi;
    assign bus.sat_lo    = sat_q.lo;
    assign bus.sat_flag  = sat_flag_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tdc_dline_decoder.sv
// Bench for tdc_dline_decoder: three instances share one stimulus stream
// (a: BUBBLE=1 no averaging, b: BUBBLE=0 no averaging, c: BUBBLE=1 AVG_LOG2=2).
module tb_tdc_dline_decoder;

    localparam int N = 16;
    localparam int W = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0] therm;
    logic         en;
    logic         clr;

    tdc_dline_decoder_if #(.NSTAGE(N)) if_a ();
    tdc_dline_decoder_if #(.NSTAGE(N)) if_b ();
    tdc_dline_decoder_if #(.NSTAGE(N)) if_c ();

    assign if_a.therm_in = therm;
    assign if_a.sample_en = en;
    assign if_a.clear = clr;
    assign if_b.therm_in = therm;
    assign if_b.sample_en = en;
    assign if_b.clear = clr;
    assign if_c.therm_in = therm;
    assign if_c.sample_en = en;
    assign if_c.clear = clr;

    tdc_dline_decoder #(.NSTAGE(N), .AVG_LOG2(0), .BUBBLE(1), .SAT_LIMIT(4)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a)
    );
    tdc_dline_decoder #(.NSTAGE(N), .AVG_LOG2(0), .BUBBLE(0), .SAT_LIMIT(4)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b)
    );
    tdc_dline_decoder #(.NSTAGE(N), .AVG_LOG2(2), .BUBBLE(1), .SAT_LIMIT(4)) dut_c (
        .clk (clk), .rst (rst), .bus (if_c)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    // a entries: {sat_flag, sat_hi, sat_lo, out}
    logic [7:0]   exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    logic [W-1:0] exp_c_q[$];

    int acc_m     = 0;
    int cnt_m     = 0;
    int sat_cnt_m = 0;
    int err_m     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_therm_tb(input logic [N-1:0] w);
        bit seen0 = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w[i]) seen0 = 1'b1;
            else if (seen0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Expected results for one decoded sample; ea/eb are the codes for a/b.
    task automatic push_model(input logic [N-1:0] word, input int ea, input int eb);
        logic hi, lo, fl;
        hi = (word == '1);
        lo = (word == '0);
        if (hi || lo) sat_cnt_m = (sat_cnt_m < 255) ? sat_cnt_m + 1 : 255;
        else sat_cnt_m = 0;
        fl = (sat_cnt_m >= 4);
        if (!is_therm_tb(word)) err_m = (err_m < 255) ? err_m + 1 : 255;
        exp_a_q.push_back({fl, hi, lo, W'(ea)});
        exp_b_q.push_back(W'(eb));
        acc_m += ea;
        cnt_m++;
        if (cnt_m == 4) begin
            exp_c_q.push_back(W'(acc_m >>> 2));
            acc_m = 0;
            cnt_m = 0;
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0]   ga;
    logic [7:0]   ea_v;
    logic [W-1:0] gv;
    logic [W-1:0] ev;

    always @(negedge clk) begin
        if (!rst) begin
            if (if_a.out_valid) begin
                if (exp_a_q.size() == 0) chk("a_unexpected_valid", if_a.out_valid, 0);
                else begin
                    ea_v = exp_a_q.pop_front();
                    ga = {if_a.sat_flag, if_a.sat_hi, if_a.sat_lo, if_a.out};
                    chk("a_out_flags", ga, ea_v);
                end
            end
            if (if_b.out_valid) begin
                if (exp_b_q.size() == 0) chk("b_unexpected_valid", if_b.out_valid, 0);
                else begin
                    ev = exp_b_q.pop_front();
                    gv = if_b.out;
                    chk("b_out", gv, ev);
                end
            end
            if (if_c.out_valid) begin
                if (exp_c_q.size() == 0) chk("c_unexpected_valid", if_c.out_valid, 0);
                else begin
                    ev = exp_c_q.pop_front();
                    gv = if_c.out;
                    chk("c_avg_out", gv, ev);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [N-1:0] word, input int ea, input int eb);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        therm = word;
        en    = 1'b1;
        push_model(word, ea, eb);
        @(negedge clk);
        en = 1'b0;
        chk("a_latency_early", if_a.out_valid, 0);
        @(negedge clk);
        chk("a_latency_2edges", if_a.out_valid, 1);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clr   = 1'b1;
        acc_m = 0;
        cnt_m = 0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Sample presented together with clear must vanish without any output.
    task automatic send_clear(input logic [N-1:0] word);
        @(negedge clk);
        @(negedge clk);
        therm = word;
        en    = 1'b1;
        clr   = 1'b1;
        acc_m = 0;
        cnt_m = 0;
        @(negedge clk);
        en  = 1'b0;
        clr = 1'b0;
        chk("clear_edge_no_valid_a", if_a.out_valid, 0);
        chk("clear_edge_no_valid_c", if_c.out_valid, 0);
        @(negedge clk);
        chk("clear_dropped_a", if_a.out_valid, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_a_out"}, {27'd0, if_a.out}, 0);
        chk({tag, "_c_out"}, {27'd0, if_c.out}, 0);
        chk({tag, "_a_valid"}, if_a.out_valid, 0);
        chk({tag, "_a_sat"}, {if_a.sat_hi, if_a.sat_lo, if_a.sat_flag}, 0);
        chk({tag, "_a_err"}, if_a.err_cnt, 0);
        chk({tag, "_b_err"}, if_b.err_cnt, 0);
    endtask

    task automatic drain_and_check_err(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_a_err_cnt"}, if_a.err_cnt, err_m);
        chk({tag, "_b_err_cnt"}, if_b.err_cnt, err_m);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [N:0] wide;
        rst   = 1'b1;
        therm = '0;
        en    = 1'b0;
        clr   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Plain thermometer decode.
        send(16'h00FF, 0, 0);
        send(16'h0FFF, 4, 4);
        send(16'h0001, -7, -7);

        // Saturation run, then release.
        repeat (4) send(16'h0000, -8, -8);
        send(16'hFFFF, 7, 7);
        send(16'h00FF, 0, 0);

        // Single bubble: filtered by a, counted raw by b.
        send(16'h00F7, 0, -1);
        drain_and_check_err("bubble");

        // Averaging windows on c, aligned by a clear.
        pulse_clear();
        send(16'h0FFF, 4, 4);
        send(16'h0FFF, 4, 4);
        send(16'h1FFF, 5, 5);
        send(16'h3FFF, 6, 6);
        send(16'h007F, -1, -1);
        send(16'h007F, -1, -1);
        send(16'h007F, -1, -1);
        send(16'h003F, -2, -2);

        // clear with a sample mid-window.
        send(16'h00FF, 0, 0);
        send(16'h00FF, 0, 0);
        send_clear(16'h0001);
        repeat (4) send(16'h07FF, 3, 3);

        // Asynchronous reset mid-window.
        send(16'h07FF, 3, 3);
        send(16'h07FF, 3, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        rst       = 1'b0;
        acc_m     = 0;
        cnt_m     = 0;
        sat_cnt_m = 0;
        err_m     = 0;
        repeat (4) send(16'h001F, -3, -3);
        drain_and_check_err("post_rst");

        // Random thermometer words, any fill level.
        repeat (16) begin
            n    = $urandom_range(0, N);
            wide = (17'h1 << n) - 17'h1;
            send(wide[N-1:0], (n >= N - 1) ? 7 : n - 8, (n >= N - 1) ? 7 : n - 8);
        end

        // Bubble counter saturation.
        repeat (256) send(16'h00F7, 0, -1);
        drain_and_check_err("err_sat");
        chk("err_sat_model", err_m, 255);

        repeat (4) @(negedge clk);
        chk("a_queue_empty", exp_a_q.size(), 0);
        chk("b_queue_empty", exp_b_q.size(), 0);
        chk("c_queue_empty", exp_c_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Time bound on the whole run.
    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tdc_dline_decoder.md
Name: tdc_dline_decoder

Overview:
Parametrised digital back-end for delay-line TDCs of any stage count. It captures the NSTAGE-bit thermometer word from the sampler bank once per reference cycle, applies optional bubble correction and converts it to a signed, saturated timing-error code. It optionally averages 2^AVG_LOG2 codes per output and tracks saturation and bubble events. It sits between the sampler array and the digital loop filter in the DPLL model.

Parameters:
NSTAGE, 16, number of delay stages / thermometer bits; even, 4..64
OUT_W, $clog2(NSTAGE)+1, signed output width (derived, not overridden)
AVG_LOG2, 0, log2 of averaging window; 0..4; 0 means no averaging
BUBBLE, 1, 0 = raw ones-count; 1 = 3-tap majority filter before counting
SAT_LIMIT, 4, consecutive saturated samples before sat_flag asserts; 1..255

Ports:
clk  input  1  sampling clock (delayed reference clock domain)
rst  input  1  asynchronous, active-high reset
therm_in  input  NSTAGE  sampler outputs; bit 0 is the earliest tap; ones fill from the LSB
sample_en  input  1  capture therm_in on this edge
clear  input  1  synchronous flush of pipeline and averaging window
out  output  OUT_W signed  timing-error code
out_valid  output  1  one-cycle pulse when out updates
sat_hi  output  1  last decoded sample was all-ones
sat_lo  output  1  last decoded sample was all-zeros
sat_flag  output  1  SAT_LIMIT or more consecutive saturated samples
err_cnt  output  8  saturating count of non-thermometer samples

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high. While rst is high, all outputs are 0, all internal valids are 0, and the accumulator, window counter and saturation counter are 0.
- Stage 1, edge n: if sample_en is high and clear is low, therm_q <= therm_in and v1 <= 1; otherwise v1 <= 0.
- Stage 2, edge n+1, when v1 is high:
  - Bubble correction: if BUBBLE=1, bit i = maj(t[i-1], t[i], t[i+1]), padded with t[-1]=1 and t[NSTAGE]=0. If BUBBLE=0, the word passes unchanged.
  - Decode: count = number of ones in the corrected word; code = count - NSTAGE/2.
  - Saturation: all-zeros gives code = -NSTAGE/2 and sat_lo=1. All-ones gives code = NSTAGE/2-1 (clamped) and sat_hi=1. For NSTAGE=16 this yields -8 and +7.
  - Bubble error: the raw therm_q is not of the form 0..01..1; err_cnt increments, saturating at 255. The check is always on the raw word, independent of BUBBLE.
  - sat_hi and sat_lo hold their value until the next decoded sample.
- Saturation counter:
  - Increments, saturating at 255, on each decoded sample with sat_hi or sat_lo set.
  - Resets to 0 on any non-saturated decoded sample.
  - sat_flag = (counter >= SAT_LIMIT), registered.
- Averaging:
  - Accumulator width is OUT_W+AVG_LOG2, signed; window counter width is AVG_LOG2.
  - On each decoded sample: acc += code.
  - When the window counter reaches 2^AVG_LOG2-1: out <= (acc+code) >>> AVG_LOG2 (arithmetic, floor), out_valid pulses, and acc and the counter return to 0.
  - AVG_LOG2=0: out = code every decoded sample.
  - Latency: out_valid is asserted 2 clk edges after the sample_en edge of the last sample in the window.
- clear:
  - Zeroes v1, the accumulator and the window counter at the next edge. out, sat_*, err_cnt and the saturation counter are held.
  - A sample presented with clear in the same cycle is dropped.
  - No out_valid is generated on the clear edge.
- Gaps in sample_en do not reset the window; only decoded samples count.
- Reset mid-window: the partial sum is discarded, and the first post-reset window starts fresh.

Decomposition:
- Package tdc_pkg:
  - function tdc_out_w(nstage) giving OUT_W
  - function is_therm(word) for the bubble check
  - constants TDC_CNT_W=8 and TDC_MAX_STAGE=64
- Sub-module tdc_therm2bin (combinational): bubble filter, ones-count, offset and clamp; parameters NSTAGE and BUBBLE; outputs code, all0, all1, bubble.
- The top level holds the pipeline registers, accumulator, saturation counter and err_cnt.

Test Plan:
- All tests use NSTAGE=16 and AVG_LOG2=0 unless stated.
- Thermometer decode: therm_in=0x00FF, then 0x0FFF, then 0x0001 -> out=0, +4, -7; out_valid 2 edges after each sample_en.
- Saturation: 0x0000 x4, then 0xFFFF x1, then 0x00FF -> out=-8 with sat_lo=1, then sat_flag=1 on the 4th sample. Next out=+7 with sat_hi=1 and sat_flag held (counter=5). On 0x00FF, sat_flag=0.
- Bubble: 0x00F7 with BUBBLE=1 -> out=0; with BUBBLE=0 -> out=-1; err_cnt increments by 1 in both cases. Also 256 bubble samples -> err_cnt=255 (saturated).
- Averaging, AVG_LOG2=2: codes +4,+4,+5,+6 -> one out=+4. Codes -1,-1,-1,-2 -> out=-2 (floor). Exactly one out_valid per 4 samples.
- clear and reset: with AVG_LOG2=2, feed 2 samples, assert clear together with a 3rd sample, then feed 4 samples of +3 -> single out=+3. Repeat with rst pulsed asynchronously mid-window -> all outputs read 0 immediately, and the next full window is correct.
